// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch stage with a DEPTH-entry prefetch buffer. Issues
//   sequential fetches on a req/ack instruction-memory port (at most one
//   outstanding), buffers returned words together with their PC, and
//   presents one instruction per cycle to the decode stage. A decode stall
//   (if_bubble) only freezes the head; prefetch keeps filling the buffer.
//   A redirect (if_pc_jump) flushes the buffer, restarts fetch at jpc and
//   drops any response that belongs to a pre-redirect request.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous reset, active low
//   jpc         in   ADDR_W  redirect target
//   if_pc_jump  in   1       redirect strobe, one cycle
//   if_bubble   in   1       decode stall: hold head, do not pop
//   im_req      out  1       fetch request valid
//   im_addr     out  ADDR_W  fetch address, stable while im_req && !im_ack
//   im_ack      in   1       memory accepts request; im_data valid this cycle
//   im_data     in   DATA_W  fetched word
//   ins_valid   out  1       ins/pc/npc hold a valid instruction
//   ins         out  DATA_W  instruction at buffer head
//   pc          out  ADDR_W  address of ins
//   npc         out  ADDR_W  pc + PC_STEP (link value)
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] jpc,
  input  logic              if_pc_jump,
  input  logic              if_bubble,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [DATA_W-1:0] im_data,
  output logic              ins_valid,
  output logic [DATA_W-1:0] ins,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(DEPTH);

  // Buffer storage: each entry keeps the fetch address alongside the word.
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] fetch_pc_r;
  logic              discard_r;
  logic              im_req_r;
  logic [ADDR_W-1:0] im_addr_r;
  logic              ins_valid_r;
  logic [DATA_W-1:0] ins_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] npc_r;

  logic              ack_s;
  logic              push_s;
  logic              pop_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_n_s;
  logic [PTR_W-1:0]  wr_ptr_n_s;
  logic [CNT_W-1:0]  count_n_s;
  logic [ADDR_W-1:0] fetch_pc_n_s;
  logic              discard_n_s;
  logic              im_req_n_s;
  logic [ADDR_W-1:0] im_addr_n_s;
  logic              ins_valid_n_s;
  logic              load_s;
  logic [ADDR_W-1:0] load_pc_s;
  logic [DATA_W-1:0] load_data_s;

  // Handshake qualifiers: an ack only counts while a request is outstanding,
  // and a redirect in the same cycle kills both the push and the pop.
  always_comb begin
    ack_s        = im_req_r & im_ack;
    push_s       = ack_s & ~discard_r & ~if_pc_jump;
    pop_s        = ins_valid_r & ~if_bubble & ~if_pc_jump;
    rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
  end

  // Buffer occupancy and pointer update (a redirect empties everything).
  always_comb begin
    count_n_s  = count_r;
    rd_ptr_n_s = rd_ptr_r;
    wr_ptr_n_s = wr_ptr_r;
    if (if_pc_jump) begin
      count_n_s  = {CNT_W{1'b0}};
      rd_ptr_n_s = {PTR_W{1'b0}};
      wr_ptr_n_s = {PTR_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_n_s  = count_r + CNT_W'(1);
          wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
        end
        2'b01: begin
          count_n_s  = count_r - CNT_W'(1);
          rd_ptr_n_s = rd_ptr_nxt_s;
        end
        2'b11: begin
          wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
          rd_ptr_n_s = rd_ptr_nxt_s;
        end
        default: begin
          count_n_s = count_r;
        end
      endcase
    end
  end

  // Request issue. A new request is only raised when the post-update count
  // leaves room, so an outstanding request always has a reserved slot. A
  // redirect that catches a request still waiting for its ack lets it finish
  // untouched and marks its response for discard.
  always_comb begin
    fetch_pc_n_s = fetch_pc_r;
    discard_n_s  = discard_r;
    im_req_n_s   = im_req_r;
    im_addr_n_s  = im_addr_r;
    if (if_pc_jump) begin
      fetch_pc_n_s = jpc;
      if (im_req_r && !im_ack) begin
        discard_n_s = 1'b1;
      end else begin
        discard_n_s = 1'b0;
        im_req_n_s  = 1'b1;
        im_addr_n_s = jpc;
      end
    end else if (ack_s) begin
      // A stale ack leaves fetch_pc alone: it already holds the redirect target.
      if (discard_r) begin
        fetch_pc_n_s = fetch_pc_r;
      end else begin
        fetch_pc_n_s = fetch_pc_r + STEP_V;
      end
      discard_n_s = 1'b0;
      im_addr_n_s = fetch_pc_n_s;
      im_req_n_s  = (count_n_s < DEPTH_V);
    end else if (!im_req_r) begin
      if (count_n_s < DEPTH_V) begin
        im_req_n_s  = 1'b1;
        im_addr_n_s = fetch_pc_r;
      end else begin
        im_req_n_s  = 1'b0;
      end
    end else begin
      im_req_n_s = 1'b1;
    end
  end

  // Head register selection: the visible outputs track the entry that will
  // be at the head after this cycle's push/pop, fed directly from the memory
  // port when the buffer is (or becomes) empty.
  always_comb begin
    ins_valid_n_s = ins_valid_r;
    load_s        = 1'b0;
    load_pc_s     = im_addr_r;
    load_data_s   = im_data;
    if (if_pc_jump) begin
      ins_valid_n_s = 1'b0;
    end else if (pop_s) begin
      if (count_r > CNT_W'(1)) begin
        load_s        = 1'b1;
        load_pc_s     = mem_pc_r[rd_ptr_nxt_s];
        load_data_s   = mem_data_r[rd_ptr_nxt_s];
        ins_valid_n_s = 1'b1;
      end else if (push_s) begin
        load_s        = 1'b1;
        ins_valid_n_s = 1'b1;
      end else begin
        ins_valid_n_s = 1'b0;
      end
    end else if (push_s && (count_r == {CNT_W{1'b0}})) begin
      load_s        = 1'b1;
      ins_valid_n_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // Buffer storage write on accepted responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_r[i]   <= {ADDR_W{1'b0}};
        mem_data_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]   <= im_addr_r;
      mem_data_r[wr_ptr_r] <= im_data;
    end else begin
      mem_pc_r[wr_ptr_r]   <= mem_pc_r[wr_ptr_r];
      mem_data_r[wr_ptr_r] <= mem_data_r[wr_ptr_r];
    end
  end

  // Control state: pointers, occupancy, fetch address, memory request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      fetch_pc_r <= RESET_PC;
      discard_r  <= 1'b0;
      im_req_r   <= 1'b0;
      im_addr_r  <= RESET_PC;
    end else begin
      rd_ptr_r   <= rd_ptr_n_s;
      wr_ptr_r   <= wr_ptr_n_s;
      count_r    <= count_n_s;
      fetch_pc_r <= fetch_pc_n_s;
      discard_r  <= discard_n_s;
      im_req_r   <= im_req_n_s;
      im_addr_r  <= im_addr_n_s;
    end
  end

  // Registered instruction outputs; values hold whenever nothing is loaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins_valid_r <= 1'b0;
      ins_r       <= {DATA_W{1'b0}};
      pc_r        <= {ADDR_W{1'b0}};
      npc_r       <= {ADDR_W{1'b0}};
    end else begin
      ins_valid_r <= ins_valid_n_s;
      if (load_s) begin
        ins_r <= load_data_s;
        pc_r  <= load_pc_s;
        npc_r <= load_pc_s + STEP_V;
      end else begin
        ins_r <= ins_r;
        pc_r  <= pc_r;
        npc_r <= npc_r;
      end
    end
  end

  assign im_req    = im_req_r;
  assign im_addr   = im_addr_r;
  assign ins_valid = ins_valid_r;
  assign ins       = ins_r;
  assign pc        = pc_r;
  assign npc       = npc_r;

endmodule
